// File: rtl/msg_cipher_pkg.sv
// ============================================================================
// Module : msg_cipher_pkg
// Brief  : Shared constants, FSM encoding and LFSR helper for the LFSR
//          message cipher hardware.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package msg_cipher_pkg;

    localparam int NUM_TAPS = 9;

    // Entry 0 sits in the low bits, so LFSR_TAPS[idx] selects tap pattern idx.
    localparam logic [NUM_TAPS-1:0][6:0] LFSR_TAPS = {
        7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
    };

    localparam logic [7:0] ASCII_OFFSET  = 8'h20;
    localparam logic [7:0] DEF_MSG_BASE  = 8'd64;
    localparam logic [7:0] DEF_OUT_BASE  = 8'd0;
    localparam int         DEF_MSG_LEN   = 64;
    localparam int         DEF_CHECK_LEN = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEED      = 3'd1,
        ST_SEARCH    = 3'd2,
        ST_DECODE_RD = 3'd3,
        ST_DECODE_WR = 3'd4,
        ST_FILL      = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] taps);
        return {s[5:0], ^(s & taps)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/msg_decrypt_lfsr7.sv
// ============================================================================
// Module : lfsr7
// Brief  : 7-bit Fibonacci LFSR register with synchronous load and step;
//          tap pattern supplied by the caller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr7
    import msg_cipher_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [6:0] i_load_val,
    input  logic       i_step,
    input  logic [6:0] i_taps,
    output logic [6:0] o_state
);

    logic [6:0] r_state;

    // Load has priority so the caller can rewind to the seed in any cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= 7'd0;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_step) begin
            r_state <= lfsr_step(r_state, i_taps);
        end
    end

    assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/msg_decrypt.sv
// ============================================================================
// Module : msg_decrypt
// Brief  : Memory-mapped LFSR message decryptor: recovers seed/taps from the
//          space preamble, decrypts, strips leading spaces, pads with spaces.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module msg_decrypt
    import msg_cipher_pkg::*;
#(
    parameter logic [7:0] MSG_BASE  = DEF_MSG_BASE,
    parameter logic [7:0] OUT_BASE  = DEF_OUT_BASE,
    parameter int         MSG_LEN   = DEF_MSG_LEN,
    parameter int         CHECK_LEN = DEF_CHECK_LEN
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic [3:0] ptrn_idx,
    output logic [6:0] seed,
    output logic [6:0] parity_err_cnt,
    output logic       no_match
);

    localparam logic [6:0] c_last_idx   = 7'(MSG_LEN - 1);
    localparam logic [6:0] c_last_check = 7'(CHECK_LEN - 1);
    localparam logic [6:0] c_msg_len    = 7'(MSG_LEN);
    localparam logic [3:0] c_last_ptrn  = 4'(NUM_TAPS - 1);

    state_t     r_state;
    logic       r_start_d;
    logic [3:0] r_p;
    logic [6:0] r_k;
    logic [6:0] r_i;
    logic [6:0] r_skip;
    logic       r_leading;
    logic [6:0] r_plain;
    logic       r_ack;
    logic [3:0] r_ptrn_idx;
    logic [6:0] r_seed;
    logic [6:0] r_perr;
    logic       r_no_match;

    logic [6:0] w_lfsr;
    logic [6:0] w_taps;
    logic       w_match;
    logic [6:0] w_plain;
    logic       w_parity_bad;
    logic       w_skip_byte;
    logic [6:0] w_fill_skip;
    logic       w_load;
    logic [6:0] w_load_val;
    logic       w_step;

    // r_p equals the accepted pattern during decode, so one tap select serves both phases.
    assign w_taps       = LFSR_TAPS[r_p];
    assign w_match      = (lfsr_step(w_lfsr, w_taps) == mem_rd_data[6:0]);
    assign w_plain      = mem_rd_data[6:0] ^ w_lfsr;
    assign w_parity_bad = mem_rd_data[7] != ^mem_rd_data[6:0];
    assign w_skip_byte  = r_leading && (w_plain == 7'd0);
    assign w_fill_skip  = (r_state == ST_DECODE_RD) ? r_skip + 7'd1 : r_skip;

    always_comb begin
        w_load     = 1'b0;
        w_load_val = r_seed;
        w_step     = 1'b0;
        case (r_state)
            ST_SEED: begin
                w_load     = 1'b1;
                w_load_val = mem_rd_data[6:0];
            end
            ST_SEARCH: begin
                if (w_match && (r_k != c_last_check)) w_step = 1'b1;
                else                                  w_load = 1'b1;
            end
            ST_DECODE_RD: w_step = w_skip_byte;
            ST_DECODE_WR: w_step = 1'b1;
            default: ;
        endcase
    end

    lfsr7 u_lfsr (
        .clk        (Clk),
        .rst_n      (Reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_step     (w_step),
        .i_taps     (w_taps),
        .o_state    (w_lfsr)
    );

    always_comb begin
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (r_state)
            ST_SEED:      mem_addr = MSG_BASE;
            ST_SEARCH:    mem_addr = MSG_BASE + {1'b0, r_k};
            ST_DECODE_RD: mem_addr = MSG_BASE + {1'b0, r_i};
            ST_DECODE_WR: begin
                mem_addr    = OUT_BASE + {1'b0, r_i - r_skip};
                mem_wr_en   = 1'b1;
                mem_wr_data = {1'b0, r_plain} + ASCII_OFFSET;
            end
            ST_FILL: begin
                mem_addr    = OUT_BASE + {1'b0, r_i};
                mem_wr_en   = 1'b1;
                mem_wr_data = ASCII_OFFSET;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_start_d  <= 1'b0;
            r_p        <= 4'd0;
            r_k        <= 7'd0;
            r_i        <= 7'd0;
            r_skip     <= 7'd0;
            r_leading  <= 1'b0;
            r_plain    <= 7'd0;
            r_ack      <= 1'b0;
            r_ptrn_idx <= 4'd0;
            r_seed     <= 7'd0;
            r_perr     <= 7'd0;
            r_no_match <= 1'b0;
        end else begin
            r_start_d <= Start;
            case (r_state)
                ST_IDLE: begin
                    if (r_start_d && !Start) begin
                        r_ptrn_idx <= 4'd0;
                        r_seed     <= 7'd0;
                        r_perr     <= 7'd0;
                        r_no_match <= 1'b0;
                        r_ack      <= 1'b0;
                        r_state    <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    r_seed  <= mem_rd_data[6:0];
                    r_p     <= 4'd0;
                    r_k     <= 7'd1;
                    r_state <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (w_match) begin
                        if (r_k == c_last_check) begin
                            r_ptrn_idx <= r_p;
                            r_i        <= 7'd0;
                            r_skip     <= 7'd0;
                            r_leading  <= 1'b1;
                            r_state    <= ST_DECODE_RD;
                        end else begin
                            r_k <= r_k + 7'd1;
                        end
                    end else if (r_p == c_last_ptrn) begin
                        r_no_match <= 1'b1;
                        r_ack      <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_p <= r_p + 4'd1;
                        r_k <= 7'd1;
                    end
                end
                ST_DECODE_RD, ST_DECODE_WR: begin
                    if (r_state == ST_DECODE_RD && w_parity_bad) r_perr <= r_perr + 7'd1;
                    if (r_state == ST_DECODE_RD && !w_skip_byte) begin
                        r_plain   <= w_plain;
                        r_leading <= 1'b0;
                        r_state   <= ST_DECODE_WR;
                    end else begin
                        if (r_state == ST_DECODE_RD) r_skip <= w_fill_skip;
                        if (r_i != c_last_idx) begin
                            r_i     <= r_i + 7'd1;
                            r_state <= ST_DECODE_RD;
                        end else if (w_fill_skip == 7'd0) begin
                            r_ack   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            // Fill resumes exactly where the shifted plaintext ends.
                            r_i     <= c_msg_len - w_fill_skip;
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (r_i == c_last_idx) begin
                        r_ack   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_i <= r_i + 7'd1;
                    end
                end
                ST_DONE: begin
                    if (Start) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Ack            = r_ack;
    assign ptrn_idx       = r_ptrn_idx;
    assign seed           = r_seed;
    assign parity_err_cnt = r_perr;
    assign no_match       = r_no_match;

endmodule

`default_nettype wire

// File: tb/tb_msg_decrypt.sv
// ============================================================================
// Module : tb_msg_decrypt
// Brief  : Scoreboard bench for msg_decrypt with a behavioural data memory
//          and a reference encryptor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_msg_decrypt;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0] idx;
        logic [6:0] seed;
        logic [6:0] perr;
        logic       nm;
    } st_t;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [3:0] ptrn_idx;
    logic [6:0] seed;
    logic [6:0] parity_err_cnt;
    logic       no_match;

    logic [7:0] mem [256];
    wr_t        exp_wr [$];
    st_t        exp_st [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       ack_q    = 1'b0;

    msg_decrypt dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start          (Start),
        .Ack            (Ack),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .ptrn_idx       (ptrn_idx),
        .seed           (seed),
        .parity_err_cnt (parity_err_cnt),
        .no_match       (no_match)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    assign mem_rd_data = mem[mem_addr];

    always @(posedge Clk) begin
        if (mem_wr_en) mem[mem_addr] = mem_wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and every Ack rise is matched against the scoreboard.
    always @(negedge Clk) begin
        if (Reset) begin
            if (mem_wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected write", {16'd0, mem_addr, mem_wr_data}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write addr/data", {16'd0, mem_addr, mem_wr_data}, {16'd0, e});
                end
            end
            if (Ack && !ack_q) begin
                if (exp_st.size() == 0) begin
                    check("unexpected ack", 32'd1, 32'd0);
                end else begin
                    st_t s;
                    s = exp_st.pop_front();
                    check("status idx/seed/perr/nm",
                          {13'd0, ptrn_idx, seed, parity_err_cnt, no_match}, {13'd0, s});
                end
            end
        end
        ack_q = Ack;
    end

    // Reference encryptor: preamble of spaces, message, space padding to 64 bytes.
    function automatic void load_block(input string msg, input int pre,
                                       input logic [6:0] taps, input logic [6:0] sd);
        logic [6:0] s;
        logic [6:0] e7;
        logic [7:0] ch;
        s = sd;
        for (int j = 0; j < 64; j++) begin
            if (j >= pre && (j - pre) < msg.len()) ch = msg[j - pre];
            else                                   ch = 8'h20;
            e7 = 7'(ch - 8'h20) ^ s;
            mem[64 + j] = {^e7, e7};
            s = {s[5:0], ^(s & taps)};
        end
    endfunction

    function automatic logic [7:0] exp_char(input string s, input int n);
        if (n < s.len()) return s[n];
        return 8'h20;
    endfunction

    function automatic void prefill_out();
        for (int a = 0; a < 64; a++) mem[a] = 8'hEE;
    endfunction

    function automatic void push_writes(input string s, input int n);
        for (int a = 0; a < n; a++) exp_wr.push_back({8'(a), exp_char(s, a)});
    endfunction

    task automatic check_image(input string name, input string s, input int n_written);
        int bad;
        logic [7:0] e;
        bad = 0;
        for (int a = 0; a < 64; a++) begin
            e = (a < n_written) ? exp_char(s, a) : 8'hEE;
            if (mem[a] !== e) bad++;
        end
        check({name, " image mismatching bytes"}, bad, 0);
    endtask

    task automatic launch();
        Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic run_and_wait(input string name);
        bit done;
        done = 1'b0;
        launch();
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge Clk);
            #1;
            if (Ack) done = 1'b1;
        end
        check({name, " ack within budget"}, 32'(done), 32'd1);
        check({name, " writes outstanding"}, exp_wr.size(), 0);
        check({name, " status outstanding"}, exp_st.size(), 0);
        Start = 1'b1;
        @(negedge Clk);
        #1;
        check({name, " ack drops in idle"}, 32'(Ack), 32'd0);
    endtask

    initial begin
        bit hit;
        Reset = 1'b0;
        Start = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        repeat (3) @(negedge Clk);
        #1;
        check("reset outputs",
              {8'd0, Ack, mem_wr_en, mem_addr, ptrn_idx, seed, no_match, 1'b0},
              32'd0);
        check("reset perr", 32'(parity_err_cnt), 32'd0);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        // "Hi", tap 0, seed 0x01
        load_block("Hi", 10, 7'h60, 7'h01);
        prefill_out();
        push_writes("Hi", 64);
        exp_st.push_back({4'd0, 7'h01, 7'd0, 1'b0});
        run_and_wait("hi");
        check_image("hi", "Hi", 64);

        // Longest search: tap 8, seed 0x55, message with its own leading space
        load_block(" Knowledge comes, but wisdom lingers.", 15, 7'h7B, 7'h55);
        prefill_out();
        push_writes("Knowledge comes, but wisdom lingers.", 64);
        exp_st.push_back({4'd8, 7'h55, 7'd0, 1'b0});
        run_and_wait("wisdom");
        check_image("wisdom", "Knowledge comes, but wisdom lingers.", 64);

        // Single parity error inside the preamble
        load_block("Hi", 10, 7'h60, 7'h01);
        mem[70] = mem[70] ^ 8'h80;
        prefill_out();
        push_writes("Hi", 64);
        exp_st.push_back({4'd0, 7'h01, 7'd1, 1'b0});
        run_and_wait("parity");
        check_image("parity", "Hi", 64);

        // Second preamble byte fits no tap pattern
        load_block("Hi", 10, 7'h60, 7'h01);
        mem[65] = {mem[65][7], 7'h7F};
        prefill_out();
        exp_st.push_back({4'd0, 7'h01, 7'd0, 1'b1});
        run_and_wait("nomatch");
        check_image("nomatch", "", 0);

        // All-space block: everything skipped, then fully filled
        load_block("", 0, 7'h60, 7'h2A);
        prefill_out();
        push_writes("", 64);
        exp_st.push_back({4'd0, 7'h2A, 7'd0, 1'b0});
        run_and_wait("allspace");
        check_image("allspace", "", 64);

        // Abort with reset on the DECODE_WR of i=20 (output address 10)
        load_block("Hi", 10, 7'h60, 7'h01);
        prefill_out();
        push_writes("Hi", 11);
        launch();
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge Clk);
            #1;
            if (mem_wr_en && mem_addr == 8'd10) hit = 1'b1;
        end
        check("abort point reached", 32'(hit), 32'd1);
        Reset = 1'b0;
        #1;
        check("abort outputs",
              {8'd0, Ack, mem_wr_en, mem_addr, ptrn_idx, seed, no_match, 1'b0},
              32'd0);
        check("abort perr", 32'(parity_err_cnt), 32'd0);
        repeat (3) @(negedge Clk);
        check("abort writes outstanding", exp_wr.size(), 0);
        check_image("abort", "Hi", 10);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        prefill_out();
        push_writes("Hi", 64);
        exp_st.push_back({4'd0, 7'h01, 7'd0, 1'b0});
        run_and_wait("rerun");
        check_image("rerun", "Hi", 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
